// File: rtl/aes_ctr_combiner.sv
// AES-CTR combiner: buffers input blocks, XORs them with in-order keystream.
// Optional CTR_COMBINER_BLKCNT_EN adds a free-running output block counter.
module aes_ctr_combiner #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] aes_key,
  input  logic [127:0] aes_ctr,
  input  logic         aes_in_valid,
  output logic         aes_in_ready,
  input  logic [127:0] aes_in_block,
  output logic         aes_out_valid,
  input  logic         aes_out_ready,
  output logic [127:0] aes_out_block,
  output logic         aes_fifo_empty,
  output logic [255:0] ks_key,
  output logic         ks_req_valid,
  input  logic         ks_req_ready,
  output logic [127:0] ks_req_block,
  input  logic         ks_rsp_valid,
  output logic         ks_rsp_ready,
  input  logic [127:0] ks_rsp_block
`ifdef CTR_COMBINER_BLKCNT_EN
  ,
  output logic [31:0]  blk_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [127:0]   mem_q [DEPTH];
  logic [127:0]   mem_d [DEPTH];
  logic           out_valid_q, out_valid_d;
  logic [127:0]   out_block_q, out_block_d;
  logic           full;
  logic           push;
  logic           pop;

  assign full = (cnt_q == CW'(DEPTH));

  // Request path is pure pass-through so the cipher sees the counter at once
  assign ks_key       = aes_key;
  assign ks_req_block = aes_ctr;
  assign ks_req_valid = aes_in_valid & ~full & ~rst;
  assign aes_in_ready = ks_req_ready & ~full & ~rst;
  assign ks_rsp_ready = (cnt_q != '0)
                      & (~out_valid_q | aes_out_ready)
                      & ~rst;

  assign push = aes_in_valid & aes_in_ready;
  assign pop  = ks_rsp_valid & ks_rsp_ready;

  assign aes_out_valid  = out_valid_q;
  assign aes_out_block  = out_block_q;
  assign aes_fifo_empty = (cnt_q == '0) & ~out_valid_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = aes_in_block;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_block_d = out_block_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_block_d = ks_rsp_block ^ mem_q[rd_ptr_q];
    end else if (aes_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_block_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_block_q <= out_block_d;
    end
  end

  // Data storage needs no reset; occupancy is tracked by cnt_q
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef CTR_COMBINER_BLKCNT_EN
  logic [31:0] blk_count_q, blk_count_d;

  always_comb begin
    blk_count_d = blk_count_q;
    if (out_valid_q & aes_out_ready) begin
      blk_count_d = blk_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_count_q <= '0;
    end else begin
      blk_count_q <= blk_count_d;
    end
  end

  assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_aes_ctr_combiner.sv
// Scoreboard bench for aes_ctr_combiner with an in-order fixed-latency
// stub cipher (ks = ctr ^ key[127:0]).
module tb_aes_ctr_combiner;

  logic         clk;
  logic         rst;
  logic [255:0] aes_key;
  logic [127:0] aes_ctr;
  logic         aes_in_valid;
  logic         aes_in_ready;
  logic [127:0] aes_in_block;
  logic         aes_out_valid;
  logic         aes_out_ready;
  logic [127:0] aes_out_block;
  logic         aes_fifo_empty;
  logic [255:0] ks_key;
  logic         ks_req_valid;
  logic         ks_req_ready;
  logic [127:0] ks_req_block;
  logic         ks_rsp_valid;
  logic         ks_rsp_ready;
  logic [127:0] ks_rsp_block;
`ifdef CTR_COMBINER_BLKCNT_EN
  logic [31:0]  blk_count;
`endif

  aes_ctr_combiner #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .aes_key        (aes_key),
    .aes_ctr        (aes_ctr),
    .aes_in_valid   (aes_in_valid),
    .aes_in_ready   (aes_in_ready),
    .aes_in_block   (aes_in_block),
    .aes_out_valid  (aes_out_valid),
    .aes_out_ready  (aes_out_ready),
    .aes_out_block  (aes_out_block),
    .aes_fifo_empty (aes_fifo_empty),
    .ks_key         (ks_key),
    .ks_req_valid   (ks_req_valid),
    .ks_req_ready   (ks_req_ready),
    .ks_req_block   (ks_req_block),
    .ks_rsp_valid   (ks_rsp_valid),
    .ks_rsp_ready   (ks_rsp_ready),
    .ks_rsp_block   (ks_rsp_block)
`ifdef CTR_COMBINER_BLKCNT_EN
    ,
    .blk_count      (blk_count)
`endif
  );

  typedef struct {
    logic [127:0] d;
    int           due;
  } stub_t;

  stub_t        stub_q[$];
  logic [127:0] exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           lat = 3;
  int           last_out = 0;
  int           prev_out = 0;
  logic         in_hs = 1'b0;
  event         sampled;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Sampler: 1ns before each rising edge, all inputs settled at negedge
  always @(negedge clk) begin
    #4;
    cyc++;
    in_hs = aes_in_valid && aes_in_ready;
    if (rst) begin
      stub_q.delete();
    end else begin
      if (ks_req_valid && ks_req_ready)
        stub_q.push_back('{d: ks_req_block ^ ks_key[127:0], due: cyc + lat});
      if (ks_rsp_valid && ks_rsp_ready && stub_q.size() > 0)
        void'(stub_q.pop_front());
    end
    if (aes_out_valid && aes_out_ready && !rst) begin
      prev_out = last_out;
      last_out = cyc;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got %h want none", aes_out_block);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        if (aes_out_block !== e) begin
          bad++;
          $display("FAIL out_block: got %h want %h", aes_out_block, e);
        end
      end
    end
    -> sampled;
  end

  // Stub cipher response driver
  always @(negedge clk) begin
    if (stub_q.size() > 0 && stub_q[0].due <= cyc + 1) begin
      ks_rsp_valid = 1'b1;
      ks_rsp_block = stub_q[0].d;
    end else begin
      ks_rsp_valid = 1'b0;
      ks_rsp_block = '0;
    end
  end

  task automatic send(input logic [127:0] ctr, input logic [127:0] blk,
                      input logic [127:0] exp, output int hs);
    int n;
    n = 0;
    hs = -1;
    @(negedge clk);
    aes_in_valid = 1'b1;
    aes_ctr      = ctr;
    aes_in_block = blk;
    while (n < 200) begin
      @(sampled);
      if (in_hs) begin
        hs = cyc;
        exp_q.push_back(exp);
        break;
      end
      n++;
    end
    if (hs < 0) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept want accept");
    end
  endtask

  task automatic idle();
    @(negedge clk);
    aes_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 300 && (exp_q.size() != 0 || aes_out_valid)) begin
      @(sampled);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  int hs, hs1, hs4, hs5, n;
  logic [127:0] ex_a, vin, vctr;

  initial begin
    rst           = 1'b1;
    aes_key       = '0;
    aes_ctr       = '0;
    aes_in_valid  = 1'b1;
    aes_in_block  = '0;
    aes_out_ready = 1'b1;
    ks_req_ready  = 1'b1;
    ks_rsp_valid  = 1'b0;
    ks_rsp_block  = '0;

    // Reset state
    @(sampled);
    @(sampled);
    chk("rst_in_ready", aes_in_ready, 0);
    chk("rst_req_valid", ks_req_valid, 0);
    chk("rst_rsp_ready", ks_rsp_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    aes_in_valid = 1'b0;
    @(sampled);
    chk("rst_out_valid", aes_out_valid, 0);
    chk("rst_out_block", aes_out_block, 0);
    chk("rst_fifo_empty", aes_fifo_empty, 1);

    // 1: single block, latency L+1
    lat = 3;
    send(128'h01, {16{8'hAA}}, {{15{8'hAA}}, 8'hAB}, hs);
    chk("t1_req_block", ks_req_block, 128'h01);
    idle();
    @(sampled);
    chk("t1_fifo_busy", aes_fifo_empty, 0);
    n = 0;
    while (!aes_out_valid && n < 50) begin
      @(sampled);
      n++;
    end
    chk("t1_latency", cyc - hs, 4);
    @(sampled);
    chk("t1_fifo_idle", aes_fifo_empty, 1);
    drain();

    // Key path: ks uses key[127:0]
    @(negedge clk);
    aes_key = {128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555,
               128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF};
    send(128'h1, 128'h0, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFE, hs);
    chk("key_hi", ks_key[255:128], 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
    chk("key_lo", ks_key[127:0], 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
    idle();
    drain();
    @(negedge clk);
    aes_key = '0;

    // 2: six blocks, L=10, full after four
    lat = 10;
    send(128'h10, 128'h1000, 128'h1010, hs1);
    send(128'h11, 128'h1100, 128'h1111, hs);
    send(128'h12, 128'h1200, 128'h1212, hs);
    send(128'h13, 128'h1300, 128'h1313, hs4);
    chk("t2_b2b", hs4 - hs1, 3);
    @(negedge clk);
    aes_ctr = 128'h14;
    aes_in_block = 128'h1400;
    @(sampled);
    chk("t2_full_ready", aes_in_ready, 0);
    chk("t2_full_req", ks_req_valid, 0);
    send(128'h14, 128'h1400, 128'h1414, hs5);
    chk("t2_resume", hs5 - hs1, 11);
    send(128'h15, 128'h1500, 128'h1515, hs);
    chk("t2_resume6", hs - hs1, 12);
    idle();
    drain();

    // 3: output backpressure with L=1
    lat = 1;
    @(negedge clk);
    aes_out_ready = 1'b0;
    send(128'h21, 128'hA0, 128'h81, hs);
    send(128'h22, 128'hB0, 128'h92, hs);
    idle();
    for (int i = 0; i < 5; i++) begin
      @(sampled);
      chk("t3_held_valid", aes_out_valid, 1);
      chk("t3_rsp_ready", ks_rsp_ready, 0);
      chk("t3_stable", aes_out_block, 128'h81);
    end
    @(negedge clk);
    aes_out_ready = 1'b1;
    drain();
    chk("t3_consecutive", last_out - prev_out, 1);

    // 4: sustained streaming wraps the pointers
    lat = 3;
    for (int i = 0; i < 12; i++) begin
      vctr = 128'(i + 1) << 4;
      vin  = {4{32'h0101_0101 * (i + 1)}};
      send(vctr, vin, vin ^ vctr, hs);
      if (i == 0) hs1 = hs;
    end
    chk("t4_no_stall", hs - hs1, 11);
    idle();
    drain();

    // Cipher request stall blocks input
    @(negedge clk);
    ks_req_ready = 1'b0;
    aes_in_valid = 1'b1;
    @(sampled);
    chk("stall_in_ready", aes_in_ready, 0);
    chk("stall_req_valid", ks_req_valid, 1);
    @(negedge clk);
    aes_in_valid = 1'b0;
    ks_req_ready = 1'b1;

    // 5: reset with three blocks in flight
    lat = 10;
    send(128'h31, 128'h3100, 128'h3131, hs);
    send(128'h32, 128'h3200, 128'h3232, hs);
    send(128'h33, 128'h3300, 128'h3333, hs);
    idle();
    @(negedge clk);
    rst = 1'b1;
    @(sampled);
    chk("t5_rst_ready", aes_in_ready, 0);
    chk("t5_rst_rsp", ks_rsp_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(sampled);
    chk("t5_out_valid", aes_out_valid, 0);
    chk("t5_fifo_empty", aes_fifo_empty, 1);
    chk("t5_in_ready", aes_in_ready, 1);
    send(128'h5, 128'h5, 128'h0, hs);
    idle();
    drain();

`ifdef CTR_COMBINER_BLKCNT_EN
    // 6: block counter and wrap
    lat = 2;
    send(128'h41, 128'h4100, 128'h4141, hs);
    send(128'h42, 128'h4200, 128'h4242, hs);
    idle();
    drain();
    chk("t6_count3", blk_count, 3);
    @(negedge clk);
    force dut.blk_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.blk_count_q;
    send(128'h43, 128'h4300, 128'h4343, hs);
    idle();
    drain();
    chk("t6_wrap", blk_count, 0);
`endif

    chk("end_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
